// File: rtl/riscv_div_pkg.sv
// rtl/riscv_div_pkg.sv - RV32M divide unit decode constants, FSM state and op types
// Shared by the iterative divider top and its restoring-step datapath.
package riscv_div_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  typedef struct packed {
    logic is_signed;
    logic want_rem;
  } div_op_t;

  function automatic logic is_div_insn(input logic [6:0] opc, input logic [6:0] f7,
                                       input logic [2:0] f3);
    logic f3_ok;
    case (f3)
      F3_DIV, F3_DIVU, F3_REM, F3_REMU: f3_ok = 1'b1;
      default:                          f3_ok = 1'b0;
    endcase
    return (opc == OPC_OP) && (f7 == F7_MULDIV) && f3_ok;
  endfunction

  function automatic div_op_t decode_op(input logic [2:0] f3);
    div_op_t op;
    op.is_signed = (f3 == F3_DIV) || (f3 == F3_REM);
    op.want_rem  = (f3 == F3_REM) || (f3 == F3_REMU);
    return op;
  endfunction

endpackage

// File: rtl/riscv_div_step.sv
// rtl/riscv_div_step.sv - one combinational radix-2 restoring division step
// The quotient register doubles as the dividend shifter: its MSB feeds the remainder.
module riscv_div_step
  import riscv_div_pkg::*;
(
  input  logic [32:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] divisor_i,
  output logic [32:0] rem_o,
  output logic [31:0] quo_o
);

  logic [33:0] shifted;
  logic [33:0] diff;

  // One guard bit above the 33-bit remainder keeps the borrow unambiguous.
  always_comb begin
    shifted = {rem_i, quo_i[31]};
    diff    = shifted - {2'b00, divisor_i};
    if (diff[33]) begin
      rem_o = shifted[32:0];
      quo_o = {quo_i[30:0], 1'b0};
    end else begin
      rem_o = diff[32:0];
      quo_o = {quo_i[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/riscv_iter_divider.sv
// rtl/riscv_iter_divider.sv - iterative RV32M DIV/DIVU/REM/REMU unit with busy/writeback handshake
// Divides operand magnitudes by restoring steps, then applies RISC-V sign rules.
module riscv_iter_divider
  import riscv_div_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        opcode_valid_i,
  input  logic [31:0] opcode_opcode_i,
  input  logic [31:0] opcode_ra_operand_i,
  input  logic [31:0] opcode_rb_operand_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        writeback_valid_o,
  output logic [31:0] writeback_value_o
);

  localparam int ITERS = XLEN / ITER_PER_CYCLE;
  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITERS - 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [32:0]      rem_q, rem_d;
  logic [31:0]      quo_q, quo_d;
  logic [31:0]      divisor_q, divisor_d;
  div_op_t          op_q, op_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             busy_q, busy_d;
  logic             wb_valid_q, wb_valid_d;
  logic [31:0]      wb_value_q, wb_value_d;

  logic        req_is_div;
  div_op_t     req_op;
  logic        accept;
  logic [31:0] a_mag, b_mag;
  logic        div_by_zero, overflow;
  logic [31:0] quo_fin, rem_fin, res_quo, res_rem;
  logic        unused_bits;

  logic [32:0] rem_chain [0:ITER_PER_CYCLE];
  logic [31:0] quo_chain [0:ITER_PER_CYCLE];

  assign rem_chain[0] = rem_q;
  assign quo_chain[0] = quo_q;

  for (genvar gi = 0; gi < ITER_PER_CYCLE; gi++) begin : g_step
    riscv_div_step u_step (
      .rem_i     (rem_chain[gi]),
      .quo_i     (quo_chain[gi]),
      .divisor_i (divisor_q),
      .rem_o     (rem_chain[gi+1]),
      .quo_o     (quo_chain[gi+1])
    );
  end

  assign req_is_div = is_div_insn(opcode_opcode_i[6:0], opcode_opcode_i[31:25],
                                  opcode_opcode_i[14:12]);
  assign req_op     = decode_op(opcode_opcode_i[14:12]);
  assign accept     = opcode_valid_i && req_is_div && !busy_q && !flush_i;

  assign a_mag = (req_op.is_signed && opcode_ra_operand_i[31]) ?
                 (32'd0 - opcode_ra_operand_i) : opcode_ra_operand_i;
  assign b_mag = (req_op.is_signed && opcode_rb_operand_i[31]) ?
                 (32'd0 - opcode_rb_operand_i) : opcode_rb_operand_i;

  assign div_by_zero = (opcode_rb_operand_i == 32'd0);
  assign overflow    = req_op.is_signed && (opcode_ra_operand_i == 32'h8000_0000) &&
                       (opcode_rb_operand_i == 32'hFFFF_FFFF);

  assign quo_fin = quo_chain[ITER_PER_CYCLE];
  assign rem_fin = rem_chain[ITER_PER_CYCLE][31:0];
  assign res_quo = neg_quo_q ? (32'd0 - quo_fin) : quo_fin;
  assign res_rem = neg_rem_q ? (32'd0 - rem_fin) : rem_fin;

  assign unused_bits = ^{opcode_opcode_i[24:15], opcode_opcode_i[11:7],
                         rem_chain[ITER_PER_CYCLE][32]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    divisor_d  = divisor_q;
    op_d       = op_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    wb_valid_d = 1'b0;
    wb_value_d = wb_value_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d      = req_op;
          divisor_d = b_mag;
          quo_d     = a_mag;
          rem_d     = '0;
          neg_quo_d = req_op.is_signed & (opcode_ra_operand_i[31] ^ opcode_rb_operand_i[31]);
          neg_rem_d = req_op.is_signed & opcode_ra_operand_i[31];
          // Architecturally defined corner cases complete without iterating.
          if (div_by_zero) begin
            state_d    = DONE;
            wb_valid_d = 1'b1;
            wb_value_d = req_op.want_rem ? opcode_ra_operand_i : 32'hFFFF_FFFF;
          end else if (overflow) begin
            state_d    = DONE;
            wb_valid_d = 1'b1;
            wb_value_d = req_op.want_rem ? 32'd0 : 32'h8000_0000;
          end else begin
            state_d = RUN;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      RUN: begin
        rem_d = rem_chain[ITER_PER_CYCLE];
        quo_d = quo_chain[ITER_PER_CYCLE];
        if (cnt_q == '0) begin
          state_d    = DONE;
          wb_valid_d = 1'b1;
          wb_value_d = op_q.want_rem ? res_rem : res_quo;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      state_d    = IDLE;
      cnt_d      = '0;
      wb_valid_d = 1'b0;
      wb_value_d = wb_value_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      op_q       <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      busy_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_value_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      divisor_q  <= divisor_d;
      op_q       <= op_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      busy_q     <= busy_d;
      wb_valid_q <= wb_valid_d;
      wb_value_q <= wb_value_d;
    end
  end

  assign busy_o            = busy_q;
  assign writeback_valid_o = wb_valid_q;
  assign writeback_value_o = wb_value_q;

endmodule
